counter_update_arbiter: RTL and testbench
=========================================

COUNTER_UPDATE_ARBITER -- requirements
Module: counter_update_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (RX handlers) sharing one packet_counter check interface.
REQ-002 SHALL have parameter QUEUE_ID_WIDTH, default 1, counter index width.
REQ-003 SHALL have parameter PACKET_SIZE_WIDTH, default 1, packet length width.
REQ-004 SHALL have parameter ISSUE_GAP, default 6, minimum cycles between successive count_o pulses (range 1..255).
REQ-005 SHALL have parameter INIT_HOLD, default 8, cycles after reset during which no request is accepted (range 0..65535).
REQ-006 SHALL have port clk_i  input  1  sole clock; all logic is rising-edge.
REQ-007 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-008 SHALL have port req_valid_i  input  NUM_REQ  per-requester update request.
REQ-009 SHALL have port req_c_id_i  input  NUM_REQ*QUEUE_ID_WIDTH  counter index; requester k at bits [k*QUEUE_ID_WIDTH +: QUEUE_ID_WIDTH].
REQ-010 SHALL have port req_p_len_i  input  NUM_REQ*PACKET_SIZE_WIDTH  packet length, same packing.
REQ-011 SHALL have port req_ready_o  output  NUM_REQ  per-requester accept, combinational, at most one bit high.
REQ-012 SHALL have port c_id_o  output  QUEUE_ID_WIDTH  registered counter index to packet_counter.
REQ-013 SHALL have port p_len_o  output  PACKET_SIZE_WIDTH  registered length to packet_counter.
REQ-014 SHALL have port count_o  output  1  registered single-cycle update strobe.
REQ-015 SHALL have port busy_o  output  1  high in INIT and GAP states.

Function
REQ-016 SHALL implement FSM states INIT, ARB, GAP.
REQ-017 INIT: all req_ready_o low; hold counter counts down from INIT_HOLD; ARB entered when it reaches 0 (INIT_HOLD=0 -> ARB the cycle after reset release).
REQ-018 ARB: winner = first k with req_valid_i[k]=1 searching from rr pointer upward, wrapping NUM_REQ-1 -> 0; req_ready_o[winner]=1 in the same cycle.
REQ-019 Transfer occurs when req_valid_i[k] and req_ready_o[k] both high at a rising edge; exactly one transfer per accepting cycle.
REQ-020 On transfer in cycle T: c_id_o/p_len_o load winner's fields, count_o=1 in cycle T+1 only; rr pointer = (winner+1) mod NUM_REQ.
REQ-021 On transfer with ISSUE_GAP>1: enter GAP, gap counter loads ISSUE_GAP-1; ISSUE_GAP=1: stay in ARB, back-to-back transfers allowed.
REQ-022 GAP: all req_ready_o low; counter decrements each cycle; ARB entered when it reaches 1; successive count_o pulses therefore exactly ISSUE_GAP cycles apart under continuous load.
REQ-023 ARB with no valid request: no transfer, count_o=0 next cycle, pointer unchanged.
REQ-024 Requesters SHALL hold valid and data stable until accepted; arbiter does not buffer unaccepted requests.
REQ-025 c_id_o/p_len_o SHALL retain last transferred values when count_o=0.
REQ-026 Fairness: with all requesters continuously valid, grants SHALL cycle 0,1,..,NUM_REQ-1,0,...; no requester waits more than NUM_REQ*ISSUE_GAP cycles after ARB entry.
REQ-027 busy_o SHALL equal (state != ARB).

Reset
REQ-028 rst_i high at any cycle, including mid-GAP or during transfer, SHALL next cycle give state=INIT, hold counter=INIT_HOLD, rr pointer=0, count_o=0, c_id_o=0, p_len_o=0, req_ready_o=0, busy_o=1.
REQ-029 A transfer coinciding with rst_i high SHALL be discarded (no count_o pulse).

Structure
REQ-030 FSM state encoding and gap/hold counter widths SHALL reside in shared package counter_arb_pkg.
REQ-031 Round-robin search SHALL be a sub-module rr_priority_select (inputs request vector, pointer; outputs one-hot grant, index, any-valid).

Verification
REQ-032 Reset release, INIT_HOLD=8, req_valid_i=4'b0001 -> req_ready_o[0] first high 8 cycles after release; count_o one cycle after acceptance.
REQ-033 All four valid continuously, ISSUE_GAP=6, c_id k=k -> count_o every 6 cycles, c_id_o sequence 0,1,2,3,0.
REQ-034 ISSUE_GAP=1, requesters 1 and 3 valid -> back-to-back count_o, c_id_o alternates 1,3,1,3.
REQ-035 Requester 2 valid alone, p_len=1500 (PACKET_SIZE_WIDTH=16) -> one count_o, p_len_o=1500, pointer=3; next requester 0 request then granted.
REQ-036 rst_i asserted in GAP cycle 3 with requesters 0,1 pending -> count_o=0, outputs zero next cycle, first post-INIT grant to requester 0.
REQ-037 Pointer=3, requests from 3 and 0 -> 3 granted first, pointer wraps to 0, 0 granted after gap.

Source files
------------

// File: rtl/counter_arb_pkg.sv
// Shared types and widths for the packet_counter update arbiter.
// State encoding and counter widths live here so sub-blocks and checkers agree.
package counter_arb_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_ARB  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Hold covers INIT_HOLD up to 65535, gap covers ISSUE_GAP up to 255.
    localparam int HOLD_W = 16;
    localparam int GAP_W  = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin priority search: first asserted request at or above ptr, wrapping.
// Produces a one-hot grant, its index and an any-request flag.
module rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);

    int k;

    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        k         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!any_valid && req[k]) begin
                any_valid = 1'b1;
                grant[k]  = 1'b1;
                idx       = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/counter_update_arbiter.sv
// Shares one packet_counter update port among NUM_REQ RX handlers with a
// round-robin grant, a post-reset hold-off and a minimum spacing between updates.
module counter_update_arbiter
    import counter_arb_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int QUEUE_ID_WIDTH    = 1,
    parameter int PACKET_SIZE_WIDTH = 1,
    parameter int ISSUE_GAP         = 6,
    parameter int INIT_HOLD         = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ*QUEUE_ID_WIDTH-1:0]    req_c_id_i,
    input  logic [NUM_REQ*PACKET_SIZE_WIDTH-1:0] req_p_len_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    output logic [QUEUE_ID_WIDTH-1:0]            c_id_o,
    output logic [PACKET_SIZE_WIDTH-1:0]         p_len_o,
    output logic                                 count_o,
    output logic                                 busy_o
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_t         state;
    arb_state_t         state_next;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] grant;
    logic               any_valid;
    logic               transfer;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_select (
        .req       (req_valid_i),
        .ptr       (rr_ptr),
        .grant     (grant),
        .idx       (win_idx),
        .any_valid (any_valid)
    );

    // Ready is only ever offered to the winner, so valid&ready reduces to this.
    assign transfer = (state == ST_ARB) && any_valid;
    assign ptr_next = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= ST_INIT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT: if (hold_cnt <= HOLD_W'(1)) state_next = ST_ARB;
            ST_ARB:  if (any_valid && (ISSUE_GAP > 1)) state_next = ST_GAP;
            ST_GAP:  if (gap_cnt <= GAP_W'(1)) state_next = ST_ARB;
            default: state_next = ST_INIT;
        endcase
    end

    always_comb begin
        req_ready_o = (state == ST_ARB) ? grant : '0;
        busy_o      = (state != ST_ARB);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_cnt <= HOLD_W'(INIT_HOLD);
            gap_cnt  <= '0;
            rr_ptr   <= '0;
            count_o  <= 1'b0;
            c_id_o   <= '0;
            p_len_o  <= '0;
        end else begin
            count_o <= transfer;
            if ((state == ST_INIT) && (hold_cnt > HOLD_W'(1)))
                hold_cnt <= hold_cnt - 1'b1;
            if (transfer) begin
                // Loading ISSUE_GAP-1 and leaving at 1 spaces pulses exactly ISSUE_GAP apart.
                gap_cnt <= GAP_W'(ISSUE_GAP - 1);
                rr_ptr  <= ptr_next;
                c_id_o  <= req_c_id_i[int'(win_idx)*QUEUE_ID_WIDTH +: QUEUE_ID_WIDTH];
                p_len_o <= req_p_len_i[int'(win_idx)*PACKET_SIZE_WIDTH +: PACKET_SIZE_WIDTH];
            end else if ((state == ST_GAP) && (gap_cnt > GAP_W'(1))) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_update_arbiter.sv
// Bench for counter_update_arbiter: two instances (gap 6/hold 8 and gap 1/hold 0)
// share one stimulus; a time-based model is compared every cycle, plus directed checks.
module tb_counter_update_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  valid;
    logic [1:0]  cid_f [4];
    logic [15:0] plen_f [4];
    logic [7:0]  cid_p;
    logic [63:0] plen_p;

    logic [3:0]  ready_a, ready_b;
    logic [1:0]  cid_a, cid_b;
    logic [15:0] plen_a, plen_b;
    logic        count_a, count_b, busy_a, busy_b;

    int checks = 0;
    int failures = 0;
    int tb_cyc = 0;
    int rel_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    always_comb begin
        cid_p  = '0;
        plen_p = '0;
        for (int k = 0; k < 4; k++) begin
            cid_p[k*2 +: 2]   = cid_f[k];
            plen_p[k*16 +: 16] = plen_f[k];
        end
    end

    counter_update_arbiter #(
        .NUM_REQ(4), .QUEUE_ID_WIDTH(2), .PACKET_SIZE_WIDTH(16), .ISSUE_GAP(6), .INIT_HOLD(8)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_c_id_i(cid_p),
        .req_p_len_i(plen_p), .req_ready_o(ready_a), .c_id_o(cid_a),
        .p_len_o(plen_a), .count_o(count_a), .busy_o(busy_a)
    );

    counter_update_arbiter #(
        .NUM_REQ(4), .QUEUE_ID_WIDTH(2), .PACKET_SIZE_WIDTH(16), .ISSUE_GAP(1), .INIT_HOLD(0)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_c_id_i(cid_p),
        .req_p_len_i(plen_p), .req_ready_o(ready_b), .c_id_o(cid_b),
        .p_len_o(plen_b), .count_o(count_b), .busy_o(busy_b)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an instance may accept once the cycle count since reset reaches
    // next_ok; each accept pushes next_ok out by the issue gap.
    int   p_gap  [2] = '{6, 1};
    int   p_hold [2] = '{8, 0};
    int   m_cyc  [2] = '{0, 0};
    int   m_next [2] = '{0, 0};
    int   m_ptr  [2] = '{0, 0};
    logic        m_cnt  [2] = '{1'b0, 1'b0};
    logic [1:0]  m_cid  [2] = '{2'd0, 2'd0};
    logic [15:0] m_plen [2] = '{16'd0, 16'd0};
    logic armed = 1'b0;

    function automatic int find_win(input logic [3:0] v, input int p);
        for (int i = 0; i < 4; i++) begin
            if (v[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                armed     <= 1'b1;
                m_cyc[i]  <= 0;
                m_next[i] <= (p_hold[i] > 1) ? p_hold[i] : 1;
                m_ptr[i]  <= 0;
                m_cnt[i]  <= 1'b0;
                m_cid[i]  <= '0;
                m_plen[i] <= '0;
            end else begin
                m_cyc[i] <= m_cyc[i] + 1;
                if (m_cyc[i] >= m_next[i] && find_win(valid, m_ptr[i]) >= 0) begin
                    m_cnt[i]  <= 1'b1;
                    m_cid[i]  <= cid_f[find_win(valid, m_ptr[i])];
                    m_plen[i] <= plen_f[find_win(valid, m_ptr[i])];
                    m_ptr[i]  <= (find_win(valid, m_ptr[i]) + 1) % 4;
                    m_next[i] <= m_cyc[i] + p_gap[i];
                end else begin
                    m_cnt[i] <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                logic       in_arb;
                int         w;
                logic [3:0] exp_ready;
                in_arb    = (m_cyc[i] >= m_next[i]);
                w         = find_win(valid, m_ptr[i]);
                exp_ready = (in_arb && w >= 0) ? (4'b0001 << w) : 4'b0000;
                check(i == 0 ? "a_ready" : "b_ready", i == 0 ? ready_a : ready_b, exp_ready);
                check(i == 0 ? "a_busy"  : "b_busy",  i == 0 ? busy_a  : busy_b,  !in_arb);
                check(i == 0 ? "a_count" : "b_count", i == 0 ? count_a : count_b, m_cnt[i]);
                check(i == 0 ? "a_cid"   : "b_cid",   i == 0 ? cid_a   : cid_b,   m_cid[i]);
                check(i == 0 ? "a_plen"  : "b_plen",  i == 0 ? plen_a  : plen_b,  m_plen[i]);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #2;
        valid = 4'b0000;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst     = 1'b0;
        rel_cyc = tb_cyc;
    endtask

    task automatic wait_ready_a(input int bitn, output int delta);
        delta = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ready_a[bitn]) begin
                delta = tb_cyc - rel_cyc;
                return;
            end
        end
    endtask

    task automatic wait_pulse(input int inst, output int cid, output int plen, output int t);
        cid = -1; plen = -1; t = -1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (inst == 0 ? count_a : count_b) begin
                cid  = int'(inst == 0 ? cid_a : cid_b);
                plen = int'(inst == 0 ? plen_a : plen_b);
                t    = tb_cyc;
                return;
            end
        end
    endtask

    initial begin
        int d, c, p, t, t_prev;
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        int alt_seq [4] = '{1, 3, 1, 3};
        rst   = 1'b1;
        valid = 4'b0000;
        for (int k = 0; k < 4; k++) cid_f[k] = 2'(k);
        plen_f[0] = 16'd100;
        plen_f[1] = 16'd200;
        plen_f[2] = 16'd1500;
        plen_f[3] = 16'd4000;

        // Hold-off after reset, then pulse and retained outputs.
        do_reset();
        @(negedge clk);
        check("rst_count", count_a, 0);
        check("rst_busy", busy_a, 1);
        @(posedge clk); #2;
        valid = 4'b0001;
        wait_ready_a(0, d);
        check("first_ready_delay", d, 8);
        @(posedge clk); #2;
        valid = 4'b0000;
        @(negedge clk);
        check("first_count", count_a, 1);
        check("first_cid", cid_a, 0);
        @(negedge clk);
        check("retain_count", count_a, 0);
        check("retain_plen", plen_a, 100);

        // All four valid: strict rotation, six cycles apart.
        do_reset();
        valid = 4'b1111;
        t_prev = -1;
        for (int j = 0; j < 5; j++) begin
            wait_pulse(0, c, p, t);
            check("rotate_cid", c, exp_seq[j]);
            if (j > 0) check("rotate_spacing", t - t_prev, 6);
            t_prev = t;
        end

        // Gap of one: back-to-back alternation between 1 and 3.
        do_reset();
        valid = 4'b1010;
        t_prev = -1;
        for (int j = 0; j < 4; j++) begin
            wait_pulse(1, c, p, t);
            check("alt_cid", c, alt_seq[j]);
            if (j > 0) check("alt_spacing", t - t_prev, 1);
            t_prev = t;
        end

        // Requester 2 alone, then 0 and 1: pointer at 3 picks 0.
        do_reset();
        valid = 4'b0100;
        wait_ready_a(2, d);
        @(posedge clk); #2;
        valid = 4'b0011;
        wait_pulse(0, c, p, t);
        check("len_cid", c, 2);
        check("len_plen", p, 1500);
        wait_pulse(0, c, p, t);
        check("after_wrap_cid", c, 0);

        // Reset in the third gap cycle with 0 and 1 pending.
        do_reset();
        valid = 4'b0001;
        wait_ready_a(0, d);
        @(posedge clk); #2;
        valid = 4'b0011;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst     = 1'b0;
        rel_cyc = tb_cyc;
        @(negedge clk);
        check("midgap_count", count_a, 0);
        check("midgap_cid", cid_a, 0);
        check("midgap_plen", plen_a, 0);
        check("midgap_busy", busy_a, 1);
        check("midgap_ready", ready_a, 0);
        wait_pulse(0, c, p, t);
        check("post_reset_cid", c, 0);

        // Pointer at 3 with 3 and 0 requesting: 3 then 0, one gap apart.
        do_reset();
        valid = 4'b0100;
        wait_ready_a(2, d);
        @(posedge clk); #2;
        valid = 4'b1001;
        wait_pulse(0, c, p, t);
        check("p3_first_cid", c, 2);
        wait_pulse(0, c, p, t_prev);
        check("p3_second_cid", c, 3);
        wait_pulse(0, c, p, t);
        check("p3_third_cid", c, 0);
        check("p3_spacing", t - t_prev, 6);

        @(posedge clk); #2;
        valid = 4'b0000;
        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
